// File: rtl/ifetch.sv
// Instruction fetch unit: one outstanding memory request, an output register
// plus a one-entry skid, redirect squashing and a sticky halt.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic        halted
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_KILL, S_HALT} state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   skid_data, skid_pc;
  logic              skid_valid;
  logic              consume, slot_free, halt_evt;
  logic              unused_pc_lsbs;

  assign consume        = ir_valid & ~stall;
  assign slot_free      = ~ir_valid | ~stall;
  assign halt_evt       = halt & ir_valid;
  assign imem_addr      = fetch_pc;
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Next state; halt outranks redirect, and an outstanding request always drains.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (halt_evt)                                   state_n = S_HALT;
        else if (!redirect && !skid_valid && !halted)   state_n = S_WAIT;
      end
      S_WAIT: begin
        if (halt_evt)                   state_n = imem_ack ? S_HALT : S_KILL;
        else if (redirect)              state_n = imem_ack ? S_IDLE : S_KILL;
        else if (imem_ack && !slot_free) state_n = S_IDLE;
      end
      S_KILL: begin
        if (imem_ack) state_n = (halted || halt_evt) ? S_HALT : S_IDLE;
      end
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      imem_req   <= 1'b0;
      fetch_pc   <= RESET_PC;
      ir         <= '0;
      ir_pc      <= '0;
      ir_valid   <= 1'b0;
      skid_data  <= '0;
      skid_pc    <= '0;
      skid_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state    <= state_n;
      imem_req <= (state_n == S_WAIT) || (state_n == S_KILL);
      if (halt_evt) begin
        ir_valid   <= 1'b0;
        skid_valid <= 1'b0;
        halted     <= 1'b1;
      end else if (redirect && !halted) begin
        ir_valid   <= 1'b0;
        skid_valid <= 1'b0;
        fetch_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (state == S_WAIT && imem_ack) begin
        // Skid is always empty in WAIT, so a response never competes with it.
        fetch_pc <= fetch_pc + XLEN'(4);
        if (slot_free) begin
          ir       <= imem_rdata;
          ir_pc    <= fetch_pc;
          ir_valid <= 1'b1;
        end else begin
          skid_data  <= imem_rdata;
          skid_pc    <= fetch_pc;
          skid_valid <= 1'b1;
        end
      end else if (skid_valid && slot_free) begin
        ir         <= skid_data;
        ir_pc      <= skid_pc;
        ir_valid   <= 1'b1;
        skid_valid <= 1'b0;
      end else if (consume) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule
